pipe_adder: RTL and testbench

- Parametrised, pipelined successor to the 32-bit ripple adder (yAdder).
- Splits a WIDTH-bit add/subtract into STAGES carry-chained chunks, one chunk per clock.
- Uses a valid/ready handshake on input and output, with full backpressure.
- Serves as the datapath arithmetic unit feeding the ALU result stage; sustains one operation per cycle.

---
 rtl/pipe_adder_pkg.sv | 28 ++
 rtl/adder_chunk.sv | 14 +
 rtl/pipe_adder.sv | 122 ++++++++++++
 tb/tb_pipe_adder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared constants, helper functions and stage control bundle for pipe_adder.
// Saturation constants are only consumed when PIPE_ADDER_SAT_EN is defined.
package pipe_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH  = 32;
  localparam int unsigned DEFAULT_STAGES = 4;
  localparam int unsigned MAX_W          = 1024;

  // Control that travels alongside each operand beat through the pipeline.
  typedef struct packed {
    logic valid;
    logic sub;
    logic carry;
  } stage_ctrl_t;

  function automatic int unsigned chunk_w(input int unsigned width, input int unsigned stages);
    return width / stages;
  endfunction

  function automatic logic [MAX_W-1:0] sat_max(input int unsigned width);
    return (MAX_W'(1) << (width - 1)) - MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] sat_min(input int unsigned width);
    return MAX_W'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CW-bit adder slice with carry in and carry out.
module adder_chunk #(
  parameter int unsigned CW = 8
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          ci,
  output logic [CW-1:0] sum_c,
  output logic          co_c
);

  assign {co_c, sum_c} = (CW+1)'(a) + (CW+1)'(b) + (CW+1)'(ci);

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/subtract, one CW-bit chunk per stage, valid/ready with global stall.
// Define PIPE_ADDER_SAT_EN to clamp overflowing results to the signed min/max.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW   = chunk_w(WIDTH, STAGES);
  localparam int unsigned LAST = STAGES - 1;

  stage_ctrl_t               ctl_q  [STAGES];
  stage_ctrl_t               ctl_in [STAGES];
  stage_ctrl_t               ctl_d  [STAGES];
  logic [WIDTH-1:0]          a_q    [STAGES];
  logic [WIDTH-1:0]          a_d    [STAGES];
  logic [WIDTH-1:0]          b_q    [STAGES];
  logic [WIDTH-1:0]          b_d    [STAGES];
  logic [WIDTH-1:0]          sum_q  [STAGES];
  logic [WIDTH-1:0]          sum_in [STAGES];
  logic [WIDTH-1:0]          sum_d  [STAGES];
  logic [STAGES-1:0][CW-1:0] chunk_sum;
  logic [STAGES-1:0]         chunk_co;
  logic                      ovf_q;
  logic                      ovf_d;
  logic                      a_msb;
  logic                      b_eff_msb;
  logic                      sum_msb;
  logic                      stall;

  assign stall    = ctl_q[LAST].valid && !out_ready;
  assign in_ready = !stall;

  // Stage inputs: port operands for stage 0, skew registers of the previous stage otherwise.
  always_comb begin
    ctl_in[0] = '{valid: in_valid, sub: sub, carry: sub | cin};
    a_d[0]    = a;
    b_d[0]    = b;
    sum_in[0] = '0;
    for (int unsigned k = 1; k < STAGES; k++) begin
      ctl_in[k] = ctl_q[k-1];
      a_d[k]    = a_q[k-1];
      b_d[k]    = b_q[k-1];
      sum_in[k] = sum_q[k-1];
    end
  end

  // Raw b is carried down the pipe; each stage inverts its own chunk in subtract mode.
  for (genvar k = 0; k < STAGES; k++) begin : g_chunk
    logic [CW-1:0] b_eff;

    assign b_eff = ctl_in[k].sub ? ~b_d[k][k*CW +: CW] : b_d[k][k*CW +: CW];

    adder_chunk #(.CW(CW)) u_chunk (
      .a     (a_d[k][k*CW +: CW]),
      .b     (b_eff),
      .ci    (ctl_in[k].carry),
      .sum_c (chunk_sum[k]),
      .co_c  (chunk_co[k])
    );
  end

  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      ctl_d[k]              = ctl_in[k];
      ctl_d[k].carry        = chunk_co[k];
      sum_d[k]              = sum_in[k];
      sum_d[k][k*CW +: CW]  = chunk_sum[k];
    end
    a_msb     = a_d[LAST][WIDTH-1];
    b_eff_msb = ctl_in[LAST].sub ^ b_d[LAST][WIDTH-1];
    sum_msb   = chunk_sum[LAST][CW-1];
    ovf_d     = (a_msb == b_eff_msb) && (sum_msb != a_msb);
`ifdef PIPE_ADDER_SAT_EN
    if (ovf_d) begin
      sum_d[LAST] = a_msb ? WIDTH'(sat_min(WIDTH)) : WIDTH'(sat_max(WIDTH));
    end
`endif
  end

  // Every stage advances together; a stall freezes the whole pipe including bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        ctl_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (!stall) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        ctl_q[k] <= ctl_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = ctl_q[LAST].valid;
  assign z         = sum_q[LAST];
  assign cout      = ctl_q[LAST].carry;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder (WIDTH=32, STAGES=4): directed vectors, backpressure, mid-flight reset.
`timescale 1ns/1ps
module tb_pipe_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] z;
  logic        cout;
  logic        ovf;

  pipe_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

`ifdef PIPE_ADDER_SAT_EN
  localparam logic [31:0] OVF_ADD_Z = 32'h7FFF_FFFF;
  localparam logic [31:0] OVF_SUB_Z = 32'h8000_0000;
`else
  localparam logic [31:0] OVF_ADD_Z = 32'h8000_0000;
  localparam logic [31:0] OVF_SUB_Z = 32'h7FFF_FFFF;
`endif

  typedef struct {
    logic [31:0] z;
    logic        cout;
    logic        ovf;
  } res_t;

  int   total = 0;
  int   bad   = 0;
  int   n_out = 0;
  res_t exp_q[$];
  res_t mon_r;
  logic was_stall = 1'b0;
  logic [31:0] held_z;
  logic held_c;
  logic held_o;
  logic bp_en = 1'b0;
  logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int   ph = 0;

  // Reference: true integer arithmetic, overflow = wrapped result differs from exact signed result.
  function automatic res_t model(input logic [31:0] av, input logic [31:0] bv,
                                 input logic ci, input logic sb);
    res_t        r;
    longint      exact;
    logic [32:0] u;
    if (sb) begin
      u      = {1'b0, av} - {1'b0, bv};
      r.cout = (av >= bv);
      exact  = longint'($signed(av)) - longint'($signed(bv));
    end else begin
      u      = {1'b0, av} + {1'b0, bv} + 33'(ci);
      r.cout = u[32];
      exact  = longint'($signed(av)) + longint'($signed(bv)) + longint'(ci);
    end
    r.z   = u[31:0];
    r.ovf = (exact != longint'($signed(u[31:0])));
`ifdef PIPE_ADDER_SAT_EN
    if (r.ovf) r.z = (exact > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard / protocol monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      was_stall = 1'b0;
    end else begin
      if (was_stall) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_z", 64'(z), 64'(held_z));
        chk("stall_cout", 64'(cout), 64'(held_c));
        chk("stall_ovf", 64'(ovf), 64'(held_o));
      end
      chk("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
      if (out_valid && out_ready) begin
        chk("result_pending", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          mon_r = exp_q.pop_front();
          chk("model_z", 64'(z), 64'(mon_r.z));
          chk("model_cout", 64'(cout), 64'(mon_r.cout));
          chk("model_ovf", 64'(ovf), 64'(mon_r.ovf));
          n_out++;
        end
      end
      was_stall = out_valid && !out_ready;
      held_z    = z;
      held_c    = cout;
      held_o    = ovf;
    end
  end

  // out_ready pattern 1,0,0,1 during the backpressure phase.
  always @(posedge clk) begin
    if (bp_en) begin
      #1;
      out_ready = pat[ph];
      ph        = (ph + 1) % 4;
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic ci, input logic sb);
    int guard = 0;
    a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("send_timeout", 64'(guard), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    if (!out_valid) chk("wait_out_timeout", 64'(n), 64'd0);
  endtask

  task automatic run_one(input string nm, input logic [31:0] av, input logic [31:0] bv,
                         input logic ci, input logic sb,
                         input logic [31:0] ez, input logic ec, input logic eo);
    int n;
    align();
    send(av, bv, ci, sb);
    in_valid = 1'b0;
    wait_out(n);
    chk({nm, "_latency"}, 64'(n), 64'd4);
    chk({nm, "_z"}, 64'(z), 64'(ez));
    chk({nm, "_cout"}, 64'(cout), 64'(ec));
    chk({nm, "_ovf"}, 64'(ovf), 64'(eo));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int base;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_z", 64'(z), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    run_one("ovf_add", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, OVF_ADD_Z, 1'b0, 1'b1);
    run_one("ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_one("sub_borrow", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_one("ovf_sub", 32'h8000_0000, 32'd1, 1'b0, 1'b1, OVF_SUB_Z, 1'b1, 1'b1);

    // Backpressure: 10 back-to-back random beats with a stuttering consumer.
    align();
    base  = n_out;
    bp_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    end
    in_valid = 1'b0;
    guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("drain_timeout", 64'(guard), 64'd0);
    chk("bp_count", 64'(n_out - base), 64'd10);
    bp_en = 1'b0;
    align();
    out_ready = 1'b1;

    // Reset with three beats in flight, the oldest already presented at the output.
    align();
    send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    send(32'h3333_3333, 32'h4444_4444, 1'b1, 1'b0);
    send(32'h5555_5555, 32'h6666_6666, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_idle", 64'(out_valid), 64'd0);
    end
    run_one("after_rst", 32'd1, 32'd2, 1'b0, 1'b0, 32'd3, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
